// File: rtl/noc_router_xy_sync.sv
// noc_router_xy_sync: 5-port XY mesh router (0 N, 1 S, 2 E, 3 W, 4 PE) with per-input FIFOs,
// per-output round-robin arbitration and registered outputs. Macro NOC_ROUTER_UTURN_CHECK_EN drops/flags U-turns.
module noc_router_xy_sync #(
  parameter int DATA_W  = 40,
  parameter int HOP_W   = 3,
  parameter int EXTRA_W = 9,
  parameter int DEPTH   = 4,
  localparam int PKT_W  = EXTRA_W + 2*(HOP_W+1) + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5*PKT_W-1:0] in_data,
  input  logic [4:0]         in_valid,
  output logic [4:0]         in_ready,
  output logic [5*PKT_W-1:0] out_data,
  output logic [4:0]         out_valid,
  input  logic [4:0]         out_ready
`ifdef NOC_ROUTER_UTURN_CHECK_EN
  ,
  output logic               err_uturn
`endif
);
  localparam int NP       = 5;
  localparam int AW       = $clog2(DEPTH);
  localparam int YHOP_LSB = DATA_W;
  localparam int YDIR_BIT = DATA_W + HOP_W;
  localparam int XHOP_LSB = YDIR_BIT + 1;
  localparam int XDIR_BIT = XHOP_LSB + HOP_W;
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [HOP_W-1:0] HOP_ONE = 1;

  logic [PKT_W-1:0] head       [NP];
  logic [PKT_W-1:0] fwd        [NP];
  logic [2:0]       route      [NP];
  logic [NP-1:0]    head_valid;
  logic [NP-1:0]    full;
  logic [NP-1:0]    pop;
  logic [NP-1:0]    drop;
  logic [NP-1:0]    req        [NP];
  logic [2:0]       grant_idx  [NP];
  logic [NP-1:0]    grant_any;
  logic [NP-1:0]    take;
  logic [2:0]       rr_ptr_q   [NP];
  logic [2:0]       rr_ptr_d   [NP];
  logic [PKT_W-1:0] out_data_q [NP];
  logic [PKT_W-1:0] out_data_d [NP];
  logic [NP-1:0]    out_valid_q;
  logic [NP-1:0]    out_valid_d;

  function automatic logic [2:0] wrap_add(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 4'd5) ? s[2:0] - 3'd5 : s[2:0];
  endfunction

  assign in_ready  = ~full;
  assign out_valid = out_valid_q;

  // Input FIFOs: the extra pointer MSB separates full from empty; head is read combinationally.
  for (genvar gi = 0; gi < NP; gi++) begin : g_in
    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             push;

    assign full[gi]       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_valid[gi] = (wr_ptr_q != rd_ptr_q);
    assign head[gi]       = mem_q[rd_ptr_q[AW-1:0]];
    assign push           = in_valid[gi] && !full[gi];

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push)    wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop[gi]) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data[gi*PKT_W +: PKT_W];
    end
  end

  // XY routing: X hops first, then Y, then local delivery.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      route[i] = 3'd4;
      fwd[i]   = head[i];
      if (head[i][XHOP_LSB +: HOP_W] != '0) begin
        route[i] = head[i][XDIR_BIT] ? 3'd2 : 3'd3;
        fwd[i][XHOP_LSB +: HOP_W] = head[i][XHOP_LSB +: HOP_W] - HOP_ONE;
      end else if (head[i][YHOP_LSB +: HOP_W] != '0) begin
        route[i] = head[i][YDIR_BIT] ? 3'd0 : 3'd1;
        fwd[i][YHOP_LSB +: HOP_W] = head[i][YHOP_LSB +: HOP_W] - HOP_ONE;
      end
    end
  end

`ifdef NOC_ROUTER_UTURN_CHECK_EN
  // Route back to own input covers both U-turns (0-3) and PE-to-PE (4).
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      drop[i] = head_valid[i] && (route[i] == 3'(i));
    end
  end

  logic err_q;
  always_ff @(posedge clk) begin
    if (rst)        err_q <= 1'b0;
    else if (|drop) err_q <= 1'b1;
  end
  assign err_uturn = err_q;
`else
  assign drop = '0;
`endif

  always_comb begin
    pop = drop;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        req[o][i] = head_valid[i] && !drop[i] && (route[i] == 3'(o));
      end
      grant_any[o] = 1'b0;
      grant_idx[o] = rr_ptr_q[o];
      for (int k = 0; k < NP; k++) begin
        if (!grant_any[o] && req[o][wrap_add(rr_ptr_q[o], 3'(k))]) begin
          grant_any[o] = 1'b1;
          grant_idx[o] = wrap_add(rr_ptr_q[o], 3'(k));
        end
      end
      // Load when the register is empty or is being drained this cycle.
      take[o]        = grant_any[o] && (!out_valid_q[o] || out_ready[o]);
      rr_ptr_d[o]    = take[o] ? wrap_add(grant_idx[o], 3'd1) : rr_ptr_q[o];
      out_valid_d[o] = out_valid_q[o] && !out_ready[o];
      out_data_d[o]  = out_data_q[o];
      if (take[o]) begin
        pop[grant_idx[o]] = 1'b1;
        out_valid_d[o]    = 1'b1;
        out_data_d[o]     = fwd[grant_idx[o]];
      end
    end
  end

  for (genvar gi = 0; gi < NP; gi++) begin : g_out
    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_q[gi] <= 1'b0;
        out_data_q[gi]  <= '0;
        rr_ptr_q[gi]    <= '0;
      end else begin
        out_valid_q[gi] <= out_valid_d[gi];
        out_data_q[gi]  <= out_data_d[gi];
        rr_ptr_q[gi]    <= rr_ptr_d[gi];
      end
    end
    assign out_data[gi*PKT_W +: PKT_W] = out_data_q[gi];
  end

endmodule

// File: tb/tb_noc_router_xy_sync.sv
// Directed bench for noc_router_xy_sync: routing, latency, arbitration, backpressure, reset and U-turn.
module tb_noc_router_xy_sync;
  localparam int PKT_W = 57;

  logic               clk = 1'b0;
  logic               rst;
  logic [5*PKT_W-1:0] in_data;
  logic [4:0]         in_valid;
  logic [4:0]         in_ready;
  logic [5*PKT_W-1:0] out_data;
  logic [4:0]         out_valid;
  logic [4:0]         out_ready;
`ifdef NOC_ROUTER_UTURN_CHECK_EN
  logic               err_uturn;
`endif

  int errors = 0;
  int checks = 0;

  noc_router_xy_sync dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef NOC_ROUTER_UTURN_CHECK_EN
    ,
    .err_uturn (err_uturn)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [PKT_W-1:0] mk(input logic [8:0] extra, input logic xdir, input logic [2:0] xhop,
                                          input logic ydir, input logic [2:0] yhop, input logic [39:0] data);
    return {extra, xdir, xhop, ydir, yhop, data};
  endfunction

  task automatic chk(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s failed", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input logic [PKT_W-1:0] pkt, input string tag);
    bit ok = 1'b0;
    in_data[p*PKT_W +: PKT_W] = pkt;
    in_valid[p] = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      ok = in_ready[p];
      tick();
    end
    in_valid[p] = 1'b0;
    chk({tag, "_accepted"}, PKT_W'(ok), PKT_W'(1));
  endtask

  task automatic pop_out(input int p, input logic [PKT_W-1:0] exp, input string tag);
    for (int c = 0; c < 50 && !out_valid[p]; c++) tick();
    chk({tag, "_valid"}, PKT_W'(out_valid[p]), PKT_W'(1));
    chk({tag, "_data"}, out_data[p*PKT_W +: PKT_W], exp);
    $display("pop port%0d %s data=%h", p, tag, out_data[p*PKT_W +: PKT_W]);
    out_ready[p] = 1'b1;
    tick();
    out_ready[p] = 1'b0;
  endtask

  task automatic burst(input logic [4:0] ports, input logic [39:0] base);
    for (int i = 0; i < 5; i++) begin
      if (ports[i]) in_data[i*PKT_W +: PKT_W] = mk(0, 0, 0, 0, 0, base + 40'(i));
    end
    chk("burst_rdy", PKT_W'(in_ready), PKT_W'(5'b11111));
    in_valid = ports;
    tick();
    in_valid = '0;
  endtask

  logic [PKT_W-1:0] exp_q [3];
  bit pend;
  bit acc;

  initial begin
    rst = 1'b1; in_data = '0; in_valid = '0; out_ready = '0;
    tick();
    tick();
    chk("rst_out_valid", PKT_W'(out_valid), '0);
    chk("rst_out_data_e", out_data[2*PKT_W +: PKT_W], '0);
    rst = 1'b0;
    chk("rst_in_ready", PKT_W'(in_ready), PKT_W'(5'b11111));

    // West to east, with latency check
    send(3, mk(9'h1A5, 1, 1, 0, 0, 40'd1), "w2e");
    chk("w2e_not_yet", PKT_W'(out_valid), '0);
    tick();
    chk("w2e_lat2_valid", PKT_W'(out_valid[2]), PKT_W'(1));
    pop_out(2, mk(9'h1A5, 1, 0, 0, 0, 40'd1), "w2e");

    send(3, mk(0, 0, 0, 1, 1, 40'd2), "w2n");
    pop_out(0, mk(0, 0, 0, 1, 0, 40'd2), "w2n");
    send(3, mk(0, 0, 0, 0, 1, 40'd3), "w2s");
    pop_out(1, mk(0, 0, 0, 0, 0, 40'd3), "w2s");
    send(3, mk(0, 0, 0, 0, 0, 40'd4), "w2pe");
    pop_out(4, mk(0, 0, 0, 0, 0, 40'd4), "w2pe");
    send(4, mk(9'h0F0, 0, 2, 1, 3, 40'd5), "pe2w");
    pop_out(3, mk(9'h0F0, 0, 1, 1, 3, 40'd5), "pe2w");

    // Contention on the PE output, one packet per cycle
    out_ready[4] = 1'b1;
    burst(5'b01011, 40'h10);
    exp_q[0] = mk(0, 0, 0, 0, 0, 40'h10);
    exp_q[1] = mk(0, 0, 0, 0, 0, 40'h11);
    exp_q[2] = mk(0, 0, 0, 0, 0, 40'h13);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("arbA_valid", PKT_W'(out_valid[4]), PKT_W'(1));
      chk("arbA_data", out_data[4*PKT_W +: PKT_W], exp_q[k]);
      $display("arbA slot%0d data=%h", k, out_data[4*PKT_W +: PKT_W]);
    end
    tick();
    chk("arbA_done", PKT_W'(out_valid[4]), '0);

    burst(5'b00011, 40'h20);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("arbB_data", out_data[4*PKT_W +: PKT_W], mk(0, 0, 0, 0, 0, 40'h20 + 40'(k)));
      $display("arbB slot%0d data=%h", k, out_data[4*PKT_W +: PKT_W]);
    end
    tick();

    // Last grant was port 1, so port 3 now leads
    burst(5'b01011, 40'h30);
    exp_q[0] = mk(0, 0, 0, 0, 0, 40'h33);
    exp_q[1] = mk(0, 0, 0, 0, 0, 40'h30);
    exp_q[2] = mk(0, 0, 0, 0, 0, 40'h31);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("arbC_data", out_data[4*PKT_W +: PKT_W], exp_q[k]);
      $display("arbC slot%0d data=%h", k, out_data[4*PKT_W +: PKT_W]);
    end
    tick();
    out_ready[4] = 1'b0;

    // Backpressure: five accepted, sixth held off
    for (int k = 0; k < 5; k++) begin
      chk("bp_rdy", PKT_W'(in_ready[3]), PKT_W'(1));
      send(3, mk(0, 1, 1, 0, 0, 40'd100 + 40'(k)), "bp_send");
    end
    chk("bp_full", PKT_W'(in_ready[3]), '0);
    in_data[3*PKT_W +: PKT_W] = mk(0, 1, 1, 0, 0, 40'd105);
    in_valid[3] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_hold_rdy", PKT_W'(in_ready[3]), '0);
      chk("bp_stable", out_data[2*PKT_W +: PKT_W], mk(0, 1, 0, 0, 0, 40'd100));
    end
    chk("bp_valid", PKT_W'(out_valid[2]), PKT_W'(1));
    out_ready[2] = 1'b1;
    acc = 1'b0;
    for (int k = 1; k < 6; k++) begin
      pend = in_valid[3] && in_ready[3];
      tick();
      if (pend) begin
        in_valid[3] = 1'b0;
        acc = 1'b1;
      end
      chk("bp_drain_valid", PKT_W'(out_valid[2]), PKT_W'(1));
      chk("bp_drain_data", out_data[2*PKT_W +: PKT_W], mk(0, 1, 0, 0, 0, 40'd100 + 40'(k)));
      $display("bp drain%0d data=%h", k, out_data[2*PKT_W +: PKT_W]);
    end
    chk("bp_sixth_accepted", PKT_W'(acc), PKT_W'(1));
    in_valid[3] = 1'b0;
    tick();
    chk("bp_empty", PKT_W'(out_valid[2]), '0);
    out_ready[2] = 1'b0;

    // Reset with packets buffered
    send(3, mk(0, 1, 1, 0, 0, 40'd200), "rs_a");
    send(3, mk(0, 1, 1, 0, 0, 40'd201), "rs_b");
    send(1, mk(0, 0, 0, 0, 0, 40'd202), "rs_c");
    tick();
    chk("rs_pre_valid", PKT_W'(out_valid), PKT_W'(5'b10100));
    rst = 1'b1;
    tick();
    chk("rs_out_valid", PKT_W'(out_valid), '0);
    chk("rs_in_ready", PKT_W'(in_ready), PKT_W'(5'b11111));
    chk("rs_out_data", out_data[2*PKT_W +: PKT_W], '0);
    rst = 1'b0;
    tick();
    tick();
    chk("rs_stays_empty", PKT_W'(out_valid), '0);

    // U-turn on the west port
    send(3, mk(0, 0, 1, 0, 0, 40'h77), "uturn");
`ifdef NOC_ROUTER_UTURN_CHECK_EN
    tick();
    tick();
    chk("uturn_err", PKT_W'(err_uturn), PKT_W'(1));
    chk("uturn_dropped", PKT_W'(out_valid), '0);
`else
    pop_out(3, mk(0, 0, 0, 0, 0, 40'h77), "uturn");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
